// File: rtl/ir_cmd_mapper_if.sv
// IR command bus between the frame decoder (master) and the channel mapper (slave).
interface ir_cmd_mapper_if #(
  parameter int N_CH   = 13,
  parameter int CODE_W = 8
);
  logic [CODE_W-1:0] data;
  logic              data_vld;
  logic              repeat_vld;
  logic [N_CH-1:0]   ch_out;
  logic              hit;
  logic              code_err;
  logic [4:0]        last_idx;

  modport master (
    output data, data_vld, repeat_vld,
    input  ch_out, hit, code_err, last_idx
  );

  modport slave (
    input  data, data_vld, repeat_vld,
    output ch_out, hit, code_err, last_idx
  );
endinterface

// File: rtl/ir_cmd_mapper.sv
// Maps IR command codes onto latched-group, toggle and momentary-hold output channels.
module ir_cmd_mapper #(
  parameter int                      N_CH       = 13,
  parameter int                      CODE_W     = 8,
  parameter logic [N_CH*CODE_W-1:0]  CODE_TABLE = {8'd22, 8'd69, 8'd82, 8'd66, 8'd28, 8'd8, 8'd24,
                                                   8'd12, 8'd21, 8'd9, 8'd7, 8'd25, 8'd64},
  parameter logic [2*N_CH-1:0]       MODE_TABLE = {2'b11, 2'b10, {6{2'b01}}, {5{2'b00}}},
  parameter logic [CODE_W-1:0]       CLR_A_CODE = 8'hFF,
  parameter logic [CODE_W-1:0]       CLR_B_CODE = 8'd13,
  parameter int                      HOLD_CYC   = 5_000_000
) (
  input logic            clk,
  input logic            rst_n,
  ir_cmd_mapper_if.slave bus
);

  localparam int              CNT_W   = $clog2(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC);

  logic [N_CH-1:0]  grp_a_m, grp_b_m, mom_m;
  logic [31:0]      mom32;

  for (genvar g = 0; g < N_CH; g++) begin : g_mode
    assign grp_a_m[g] = (MODE_TABLE[2*g +: 2] == 2'b00);
    assign grp_b_m[g] = (MODE_TABLE[2*g +: 2] == 2'b01);
    assign mom_m[g]   = (MODE_TABLE[2*g +: 2] == 2'b11);
  end
  assign mom32 = 32'(mom_m);

  logic [N_CH-1:0]  ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic             hit_q, hit_d;
  logic             err_q, err_d;
  logic [4:0]       idx_q, idx_d;
  logic             lv_q, lv_d;

  logic             match_any;
  logic [4:0]       match_idx;
  logic [1:0]       match_mode;
  logic             rep_act;

  // Ascending scan with a found flag so duplicate codes resolve to the lowest index.
  always_comb begin
    match_any  = 1'b0;
    match_idx  = '0;
    match_mode = 2'b00;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!match_any && (CODE_TABLE[i*CODE_W +: CODE_W] == bus.data)) begin
        match_any  = 1'b1;
        match_idx  = 5'(i);
        match_mode = MODE_TABLE[2*i +: 2];
      end
    end
  end

  assign rep_act = bus.repeat_vld && lv_q && mom32[idx_q];

  always_comb begin
    ch_d  = ch_q;
    hit_d = 1'b0;
    err_d = 1'b0;
    idx_d = idx_q;
    lv_d  = lv_q;

    for (int unsigned i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
        if (cnt_q[i] == CNT_W'(1)) ch_d[i] = 1'b0;
      end
    end

    // Reloads below override the expiry above, so a reload on the last count never glitches low.
    if (bus.data_vld) begin
      if (bus.data == CLR_A_CODE) begin
        ch_d  = ch_d & ~grp_a_m;
        hit_d = 1'b1;
        lv_d  = 1'b0;
      end else if (bus.data == CLR_B_CODE) begin
        ch_d  = ch_d & ~grp_b_m;
        hit_d = 1'b1;
        lv_d  = 1'b0;
      end else if (match_any) begin
        hit_d = 1'b1;
        lv_d  = 1'b1;
        idx_d = match_idx;
        case (match_mode)
          2'b00:   ch_d = ch_d & ~grp_a_m;
          2'b01:   ch_d = ch_d & ~grp_b_m;
          default: ;
        endcase
        for (int unsigned i = 0; i < N_CH; i++) begin
          if (5'(i) == match_idx) begin
            case (match_mode)
              2'b10: ch_d[i] = ~ch_q[i];
              2'b11: begin
                ch_d[i]  = 1'b1;
                cnt_d[i] = HOLD_LD;
              end
              default: ch_d[i] = 1'b1;
            endcase
          end
        end
      end else begin
        err_d = 1'b1;
        lv_d  = 1'b0;
      end
    end else if (rep_act) begin
      hit_d = 1'b1;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (5'(i) == idx_q) begin
          ch_d[i]  = 1'b1;
          cnt_d[i] = HOLD_LD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ch_q  <= '0;
      hit_q <= 1'b0;
      err_q <= 1'b0;
      idx_q <= '0;
      lv_q  <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      ch_q  <= ch_d;
      hit_q <= hit_d;
      err_q <= err_d;
      idx_q <= idx_d;
      lv_q  <= lv_d;
      for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.ch_out   = ch_q;
  assign bus.hit      = hit_q;
  assign bus.code_err = err_q;
  assign bus.last_idx = idx_q;

endmodule

// File: tb/tb_ir_cmd_mapper.sv
// Directed bench for ir_cmd_mapper with a short momentary hold time.
module tb_ir_cmd_mapper;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ir_cmd_mapper_if #(.N_CH(13), .CODE_W(8)) bus ();

  ir_cmd_mapper #(.HOLD_CYC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of strobes; returns at the following negedge with outputs updated.
  task automatic strobe(input logic [7:0] code, input logic dv, input logic rv);
    bus.data       = code;
    bus.data_vld   = dv;
    bus.repeat_vld = rv;
    @(negedge clk);
    bus.data_vld   = 1'b0;
    bus.repeat_vld = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    int n;
    int lows;
    int hits;
    checks = 0;
    errors = 0;
    bus.data = '0;
    bus.data_vld = 1'b0;
    bus.repeat_vld = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;

    check("rst_ch", 32'(bus.ch_out), 32'h0);
    check("rst_hit", 32'(bus.hit), 32'h0);
    check("rst_err", 32'(bus.code_err), 32'h0);
    check("rst_idx", 32'(bus.last_idx), 32'h0);

    // 1: group A one-hot
    hits = 0;
    strobe(8'd64, 1, 0); check("a64_ch", 32'(bus.ch_out), 32'h001); hits += int'(bus.hit);
    strobe(8'd25, 1, 0); check("a25_ch", 32'(bus.ch_out), 32'h002); hits += int'(bus.hit);
    strobe(8'd21, 1, 0); check("a21_ch", 32'(bus.ch_out), 32'h010); hits += int'(bus.hit);
    check("a_idx", 32'(bus.last_idx), 32'd4);
    idle();
    check("a_hit_drop", 32'(bus.hit), 32'h0);
    check("a_hits", 32'(hits), 32'd3);

    // 2: group independence and clears
    strobe(8'd64, 1, 0);
    strobe(8'd12, 1, 0); check("grp_ch", 32'(bus.ch_out), 32'h021);
    check("grp_idx", 32'(bus.last_idx), 32'd5);
    strobe(8'd13, 1, 0); check("clrb_ch", 32'(bus.ch_out), 32'h001);
    check("clrb_hit", 32'(bus.hit), 32'h1);
    strobe(8'hFF, 1, 0); check("clra_ch", 32'(bus.ch_out), 32'h000);
    check("clra_hit", 32'(bus.hit), 32'h1);

    // 3: toggle, repeats ignored
    strobe(8'd69, 1, 0); check("tog1", 32'(bus.ch_out), 32'h800);
    strobe(8'd69, 1, 0); check("tog2", 32'(bus.ch_out), 32'h000);
    strobe(8'd69, 1, 0); check("tog3", 32'(bus.ch_out), 32'h800);
    for (int i = 0; i < 4; i++) begin
      strobe(8'd0, 0, 1);
      check("tog_rep_ch", 32'(bus.ch_out), 32'h800);
      check("tog_rep_hit", 32'(bus.hit), 32'h0);
    end

    // 4a: plain hold lasts 8 cycles
    strobe(8'd22, 1, 0);
    check("mom_idx", 32'(bus.last_idx), 32'd12);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (!bus.ch_out[12]) break;
      n++;
    end
    check("mom_len8", 32'(n), 32'd8);

    // 4b: repeat on the 7th edge extends to 15 cycles
    strobe(8'd22, 1, 0);
    n = 1;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (bus.ch_out[12]) n++;
    end
    strobe(8'd0, 0, 1);
    check("mom_rep_hit", 32'(bus.hit), 32'h1);
    if (bus.ch_out[12]) n++;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (!bus.ch_out[12]) break;
      n++;
    end
    check("mom_len15", 32'(n), 32'd15);

    // 4c: repeat on the expiry edge leaves no low cycle
    strobe(8'd22, 1, 0);
    n = 1;
    lows = 0;
    for (int i = 0; i < 7; i++) begin
      idle();
      if (bus.ch_out[12]) n++; else lows++;
    end
    strobe(8'd0, 0, 1);
    if (bus.ch_out[12]) n++; else lows++;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (!bus.ch_out[12]) break;
      n++;
    end
    check("mom_exp_lows", 32'(lows), 32'd0);
    check("mom_len16", 32'(n), 32'd16);

    // 5: unmapped code, then simultaneous strobes
    strobe(8'd99, 1, 0);
    check("unm_err", 32'(bus.code_err), 32'h1);
    check("unm_hit", 32'(bus.hit), 32'h0);
    check("unm_ch", 32'(bus.ch_out), 32'h800);
    check("unm_idx", 32'(bus.last_idx), 32'd12);
    idle();
    check("unm_err_drop", 32'(bus.code_err), 32'h0);
    strobe(8'd0, 0, 1);
    check("unm_rep_hit", 32'(bus.hit), 32'h0);
    check("unm_rep_ch", 32'(bus.ch_out), 32'h800);

    strobe(8'd22, 1, 1);
    check("sim_ch", 32'(bus.ch_out), 32'h1800);
    check("sim_err", 32'(bus.code_err), 32'h0);
    hits = int'(bus.hit);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      idle();
      hits += int'(bus.hit);
      if (!bus.ch_out[12]) break;
      n++;
    end
    check("sim_hits", 32'(hits), 32'd1);
    check("sim_len8", 32'(n), 32'd8);

    // 6: reset in the middle of a hold
    strobe(8'd22, 1, 0);
    idle();
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    check("rsth_ch", 32'(bus.ch_out), 32'h0);
    check("rsth_idx", 32'(bus.last_idx), 32'h0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      idle();
      if (bus.ch_out != '0) n++;
    end
    check("rsth_stay0", 32'(n), 32'd0);
    strobe(8'd0, 0, 1);
    check("rsth_rep_hit", 32'(bus.hit), 32'h0);
    check("rsth_rep_ch", 32'(bus.ch_out), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_cmd_mapper.md
Name: ir_cmd_mapper

Overview:
Parametrised decoder that maps IR-remote command codes onto a bank of control channels driving the robot actuators (motor direction, mode select, servo). Each channel is configured as exclusive-latched within group A or group B, as a toggle, or as a momentary hold with timeout. The block sits between the IR frame decoder, which supplies a code, a new-frame strobe and a repeat strobe, and the motor/servo control blocks.

Parameters:
N_CH, 13, number of output channels (1..32)
CODE_W, 8, command code width
CODE_TABLE, {8'd22,8'd69,8'd82,8'd66,8'd28,8'd8,8'd24,8'd12,8'd21,8'd9,8'd7,8'd25,8'd64}, flattened N_CH*CODE_W; channel i code at bits [i*CODE_W +: CODE_W]
MODE_TABLE, {2'b11,2'b10,{6{2'b01}},{5{2'b00}}}, flattened 2*N_CH; 00 = group A exclusive, 01 = group B exclusive, 10 = toggle, 11 = momentary
CLR_A_CODE, 8'hFF, code that clears all group-A channels
CLR_B_CODE, 8'd13, code that clears all group-B channels
HOLD_CYC, 5_000_000, momentary hold time in clk cycles (min 2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-high: asserted when 1 (the name follows the codebase; polarity and synchronicity are fixed)
data  in  CODE_W  command code from the IR decoder; valid only with a strobe
data_vld  in  1  one-cycle strobe: new frame decoded
repeat_vld  in  1  one-cycle strobe: key-held repeat frame (carries no code)
ch_out  out  N_CH  channel levels
hit  out  1  one-cycle pulse: a frame or repeat changed or refreshed channel state
code_err  out  1  one-cycle pulse: data_vld carried an unmapped code
last_idx  out  5  index of the last matched channel

Behaviour:
- Reset (rst_n = 1 at a clk edge): ch_out = 0, hit = 0, code_err = 0, last_idx = 0, last_valid = 0, all hold counters = 0. Reset has priority over all strobes and aborts any momentary hold in progress.
- Match: combinational compare of data against every table entry. Duplicate codes resolve to the lowest index. The clear codes are checked before the table.
- Latency: a strobe sampled at edge k updates ch_out, hit, code_err and last_idx at edge k, so they are visible one cycle after the strobe.
- data_vld with a matched channel i, by mode:
  - 00/01: set ch_out[i]; clear every other channel of the same group; the other group is untouched.
  - 10: ch_out[i] inverts.
  - 11: ch_out[i] = 1; hold counter i reloads to HOLD_CYC.
  - In all modes: hit = 1, last_idx = i, last_valid = 1.
- data_vld with CLR_A_CODE or CLR_B_CODE: clear all channels of that group; hit = 1; last_valid = 0.
- data_vld with an unmapped code: code_err = 1; no channel changes; last_valid = 0.
- repeat_vld: acts only if last_valid = 1 and channel last_idx is momentary. It reloads that channel's counter and pulses hit. In every other case repeat_vld is ignored; in particular toggles never re-toggle on repeat and latched channels are unaffected.
- Simultaneous data_vld and repeat_vld: data_vld wins and repeat_vld is dropped.
- Momentary counter: decrements each cycle while non-zero. On the transition 1 -> 0, ch_out[i] clears on the same edge. A reload in the same cycle as the expiry wins, so the output stays high with no glitch.
- Group A and group B channel sets are independent. A group with no members makes its clear code a no-op that still pulses hit.

Test Plan:
1. Reset, then data_vld with 64, 25, 21 in turn -> ch_out[0], then ch_out[1], then ch_out[4] each one-hot in group A one cycle after its strobe; hit pulses 3 times; last_idx = 4.
2. Group independence: 64 then 12 -> ch_out = 13'h021; send 13 (CLR_B) -> ch_out = 13'h001; send 0xFF (CLR_A) -> ch_out = 0.
3. Toggle: 69 three times -> ch_out[11] = 1, 0, 1; repeat_vld x4 after the third -> ch_out[11] stays 1 and hit stays 0.
4. Momentary with HOLD_CYC = 8: send 22 -> ch_out[12] high for exactly 8 cycles. Next, send 22 then repeat_vld at cycle 7 -> high for 15 cycles total. Finally, repeat_vld on exactly the expiry cycle -> no low cycle on ch_out[12].
5. Unmapped and simultaneous: data_vld with 99 -> code_err pulse, ch_out unchanged, a following repeat_vld ignored; data_vld = 22 with repeat_vld on the same cycle -> one hit, counter = HOLD_CYC.
6. Reset mid-hold: assert rst_n for 1 cycle at hold cycle 3 -> ch_out = 0 on the next edge and stays 0, with counter 0.
